// File: rtl/regfile_pkg.sv
// Shared constants and the address-width helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_REG_NUM = 32;
    localparam int unsigned DEF_NRD     = 2;
    localparam int unsigned DEF_NWR     = 2;
    localparam int unsigned REG_ZERO    = 0;

    function automatic int unsigned aw_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback bus of the register file; master = pipeline, slave = register file.
interface regfile_mp_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned REG_NUM = DEF_REG_NUM,
    parameter int unsigned NRD     = DEF_NRD,
    parameter int unsigned NWR     = DEF_NWR,
    parameter int unsigned AW      = aw_of(REG_NUM)
);
    logic [NRD-1:0]       RD_EN;
    logic [NRD*AW-1:0]    RD_ADR;
    logic [NRD*WIDTH-1:0] RD_DATA;
    logic [NWR-1:0]       WE;
    logic [NWR*AW-1:0]    WR_ADR;
    logic [NWR*WIDTH-1:0] WD;
    logic                 ISSUE_VLD;
    logic [AW-1:0]        ISSUE_ADR;
    logic [REG_NUM-1:0]   PEND;
    logic                 STALL;

    modport master (
        output RD_EN, RD_ADR, WE, WR_ADR, WD, ISSUE_VLD, ISSUE_ADR,
        input  RD_DATA, PEND, STALL
    );

    modport slave (
        input  RD_EN, RD_ADR, WE, WR_ADR, WD, ISSUE_VLD, ISSUE_ADR,
        output RD_DATA, PEND, STALL
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: issue sets a register's bit, writeback clears it, set beats clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned REG_NUM = DEF_REG_NUM,
    parameter int unsigned NWR     = DEF_NWR,
    parameter int unsigned AW      = aw_of(REG_NUM)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NWR-1:0]     we,
    input  logic [NWR*AW-1:0]  wr_adr,
    input  logic               issue_vld,
    input  logic [AW-1:0]      issue_adr,
    output logic [REG_NUM-1:0] pend
);

    logic [REG_NUM-1:0] pend_nxt;

    always_comb begin
        pend_nxt = pend;
        for (int unsigned w = 0; w < NWR; w++) begin
            if (we[w]) begin
                pend_nxt[wr_adr[w*AW +: AW]] = 1'b0;
            end
        end
        // Younger issue owns the register, so the set is applied after all clears.
        if (issue_vld) begin
            pend_nxt[issue_adr] = 1'b1;
        end
        pend_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with hardwired r0 and pending-write scoreboard.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned REG_NUM = DEF_REG_NUM,
    parameter int unsigned NRD     = DEF_NRD,
    parameter int unsigned NWR     = DEF_NWR,
    parameter int unsigned AW      = aw_of(REG_NUM)
) (
    input  logic            CLK,
    input  logic            RST,
    regfile_mp_sb_if.slave  bus
);

    logic [WIDTH-1:0]     mem [REG_NUM];
    logic [REG_NUM-1:0]   pend;
    logic [NRD*WIDTH-1:0] rd_data;
    logic                 stall;

    regfile_scoreboard #(
        .REG_NUM (REG_NUM),
        .NWR     (NWR),
        .AW      (AW)
    ) u_sb (
        .CLK       (CLK),
        .RST       (RST),
        .we        (bus.WE),
        .wr_adr    (bus.WR_ADR),
        .issue_vld (bus.ISSUE_VLD),
        .issue_adr (bus.ISSUE_ADR),
        .pend      (pend)
    );

    // Ports are visited in ascending order so the highest-index writer lands last.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NWR; w++) begin
                if (bus.WE[w] && bus.WR_ADR[w*AW +: AW] != AW'(REG_ZERO)) begin
                    mem[bus.WR_ADR[w*AW +: AW]] <= bus.WD[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0]    adr;
        logic [WIDTH-1:0] dat;
        logic             hit;
        rd_data = '0;
        stall   = 1'b0;
        for (int unsigned p = 0; p < NRD; p++) begin
            adr = bus.RD_ADR[p*AW +: AW];
            dat = (adr == AW'(REG_ZERO)) ? '0 : mem[adr];
            hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
            for (int unsigned w = 0; w < NWR; w++) begin
                if (bus.WE[w] && bus.WR_ADR[w*AW +: AW] == adr && adr != AW'(REG_ZERO)) begin
                    dat = bus.WD[w*WIDTH +: WIDTH];
                    hit = 1'b1;
                end
            end
`endif
            rd_data[p*WIDTH +: WIDTH] = dat;
            if (bus.RD_EN[p] && pend[adr] && !hit) begin
                stall = 1'b1;
            end
        end
        // Bypassed write data must not leak out while reset is held.
        if (RST) begin
            rd_data = '0;
            stall   = 1'b0;
        end
    end

    assign bus.RD_DATA = rd_data;
    assign bus.STALL   = stall;
    assign bus.PEND    = pend;

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  localparam int unsigned AW = 5;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  regfile_mp_sb_if #(.WIDTH(32), .REG_NUM(32), .NRD(2), .NWR(2), .AW(AW)) bus ();

  regfile_mp_sb #(.WIDTH(32), .REG_NUM(32), .NRD(2), .NWR(2), .AW(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];

  task automatic expect_(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cycle;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
    bus.WE        = '0;
    bus.ISSUE_VLD = 1'b0;
    bus.ISSUE_ADR = '0;
    bus.RD_EN     = '0;
  endtask

  task automatic wr(input int port, input logic [4:0] adr, input logic [31:0] d);
    bus.WE[port]            = 1'b1;
    bus.WR_ADR[port*5 +: 5] = adr;
    bus.WD[port*32 +: 32]   = d;
  endtask

  task automatic rd(input int port, input logic en, input logic [4:0] adr);
    bus.RD_EN[port]         = en;
    bus.RD_ADR[port*5 +: 5] = adr;
  endtask

  task automatic issue(input logic [4:0] adr);
    bus.ISSUE_VLD = 1'b1;
    bus.ISSUE_ADR = adr;
  endtask

  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = bus.RD_DATA[31:0];
        1:       act = bus.RD_DATA[63:32];
        2:       act = {31'b0, bus.STALL};
        default: act = bus.PEND;
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, e.cyc);
      end
    end
  end

  initial begin
    bus.RD_EN = '0; bus.RD_ADR = '0; bus.WE = '0; bus.WR_ADR = '0; bus.WD = '0;
    bus.ISSUE_VLD = 1'b0; bus.ISSUE_ADR = '0;

    next_cycle();
    rd(0, 1'b1, 5'd1);
    expect_(0, 32'h0, "reset_rd0");
    expect_(2, 32'h0, "reset_stall");
    expect_(3, 32'h0, "reset_pend");
    RST = 1'b0;

    next_cycle();
    wr(0, 5'd0, 32'hDEADBEEF);
    issue(5'd0);
    next_cycle();
    rd(0, 1'b1, 5'd0);
    expect_(0, 32'h0, "r0_read");
    expect_(3, 32'h0, "r0_issue_pend");

    next_cycle();
    wr(0, 5'd5, 32'h11);
    wr(1, 5'd5, 32'h22);
    next_cycle();
    rd(0, 1'b0, 5'd5);
    rd(1, 1'b0, 5'd5);
    expect_(0, 32'h22, "collision_p0");
    expect_(1, 32'h22, "collision_p1");

    next_cycle();
    issue(5'd7);
    next_cycle();
    rd(1, 1'b1, 5'd7);
    expect_(2, 32'h1, "pend7_stall");
    expect_(3, 32'h80, "pend7_set");
    #1;
    checks++;
    if (bus.PEND !== 32'h80) begin
      failures++;
      $display("FAIL pend7_direct: got %h expected %h", bus.PEND, 32'h80);
    end
    next_cycle();
    rd(1, 1'b1, 5'd7);
    wr(0, 5'd7, 32'h1234);
`ifdef REGFILE_BYPASS_EN
    expect_(1, 32'h1234, "wb7_bypass_data");
    expect_(2, 32'h0, "wb7_bypass_stall");
`else
    expect_(1, 32'h0, "wb7_old_data");
    expect_(2, 32'h1, "wb7_stall");
`endif
    next_cycle();
    rd(1, 1'b1, 5'd7);
    expect_(3, 32'h0, "wb7_pend_clr");
    expect_(2, 32'h0, "wb7_stall_clr");
    expect_(1, 32'h1234, "wb7_data");
    #1;
    checks++;
    if (bus.RD_DATA[63:32] !== 32'h1234) begin
      failures++;
      $display("FAIL wb7_data_direct: got %h expected %h", bus.RD_DATA[63:32], 32'h1234);
    end

    next_cycle();
    issue(5'd9);
    next_cycle();
    wr(0, 5'd9, 32'h99);
    issue(5'd9);
    next_cycle();
    rd(0, 1'b0, 5'd9);
    expect_(3, 32'h200, "race_pend9");
    expect_(0, 32'h99, "race_data9");
    #1;
    checks++;
    if (bus.PEND !== 32'h200) begin
      failures++;
      $display("FAIL race_pend9_direct: got %h expected %h", bus.PEND, 32'h200);
    end
    next_cycle();
    wr(1, 5'd9, 32'h999);
    next_cycle();
    expect_(3, 32'h0, "race_pend9_clr");

    next_cycle();
    wr(0, 5'd3, 32'h3333);
    next_cycle();
    issue(5'd3);
    next_cycle();
    rd(0, 1'b1, 5'd3);
    wr(1, 5'd3, 32'hCAFE);
`ifdef REGFILE_BYPASS_EN
    expect_(0, 32'hCAFE, "byp3_data");
    expect_(2, 32'h0, "byp3_stall");
`else
    expect_(0, 32'h3333, "nobyp3_data");
    expect_(2, 32'h1, "nobyp3_stall");
`endif
    next_cycle();
    rd(0, 1'b1, 5'd3);
    expect_(0, 32'hCAFE, "r3_after");
    expect_(2, 32'h0, "r3_stall_after");

    next_cycle();
    issue(5'd4);
    wr(0, 5'd10, 32'hAAAA);
    next_cycle();
    rd(0, 1'b0, 5'd4);
    wr(1, 5'd12, 32'h1212);
    expect_(2, 32'h0, "rden_gate");
    expect_(3, 32'h10, "pend4");
    next_cycle();
    rd(0, 1'b1, 5'd4);
    rd(1, 1'b0, 5'd12);
    expect_(2, 32'h1, "rden_stall");
    expect_(3, 32'h10, "nonpend_write_pend");
    expect_(1, 32'h1212, "r12_data");

    next_cycle();
    rd(0, 1'b1, 5'd4);
    rd(1, 1'b0, 5'd10);
    wr(0, 5'd10, 32'hBBBB);
    issue(5'd11);
    #2 RST = 1'b1;
    expect_(1, 32'h0, "rst_mid_rd1");
    expect_(2, 32'h0, "rst_mid_stall");
    expect_(3, 32'h0, "rst_mid_pend");
    next_cycle();
    RST = 1'b0;
    rd(1, 1'b0, 5'd10);
    rd(0, 1'b0, 5'd12);
    expect_(1, 32'h0, "post_rst_r10");
    expect_(0, 32'h0, "post_rst_r12");
    expect_(3, 32'h0, "post_rst_pend");
    #1;
    checks++;
    if (bus.PEND !== 32'h0) begin
      failures++;
      $display("FAIL post_rst_pend_direct: got %h expected %h", bus.PEND, 32'h0);
    end

    repeat (3) @(posedge CLK);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: not checked, expected %h", e.name, e.val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the MIPS pipeline. Generalises the single-write/dual-read file to NRD read ports and NWR write ports.
- Adds a hardwired zero register and an optional write-to-read bypass.
- Adds an integrated pending-write scoreboard that flags reads of registers still waiting for writeback, so decode can stall.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
- WIDTH, 32, data width of each register.
- REG_NUM, 32, number of architectural registers; AW = $clog2(REG_NUM).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports (e.g. ALU and load writeback).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- RD_EN  in  NRD  per-port read-valid; qualifies the stall check only.
- RD_ADR  in  NRD*AW  read addresses, port p at [p*AW +: AW].
- RD_DATA  out  NRD*WIDTH  combinational read data, port p at [p*WIDTH +: WIDTH].
- WE  in  NWR  per-port write enable.
- WR_ADR  in  NWR*AW  write addresses.
- WD  in  NWR*WIDTH  write data.
- ISSUE_VLD  in  1  an instruction with a destination is issued this cycle.
- ISSUE_ADR  in  AW  destination register of the issued instruction.
- PEND  out  REG_NUM  registered scoreboard vector; bit r = write to r outstanding.
- STALL  out  1  combinational; 1 when any enabled read port hits a pending register.

Behaviour:
- Reset:
  - RST=1 asynchronously clears every register to 0 and PEND to 0.
  - While RST is asserted: RD_DATA = 0 and STALL = 0.
  - Reset mid-operation discards all in-flight writes and pending marks.
- Write (rising edge):
  - For each port w with WE[w]=1 and WR_ADR≠0: MEM[WR_ADR] <= WD.
  - Same address on multiple ports: the highest-index port wins.
  - Writes to address 0 are dropped.
- Read (combinational):
  - RD_DATA[p] = MEM[RD_ADR[p]].
  - Address 0 always returns 0.
  - RD_EN does not gate data.
- Scoreboard (rising edge), for each r≠0:
  - PEND[r] set when ISSUE_VLD && ISSUE_ADR==r.
  - PEND[r] cleared when any WE[w] && WR_ADR[w]==r.
  - Set and clear of the same r in the same cycle: set wins (the younger instruction owns the register).
  - ISSUE_ADR=0 is ignored; PEND[0] is always 0.
  - Re-issue to an already pending r leaves it pending. There is no counting: a single writeback clears it.
  - A write to a non-pending register performs the data write and leaves PEND unchanged.
- Stall:
  - STALL = OR over p of (RD_EN[p] && PEND[RD_ADR[p]] && !cleared_this_cycle(RD_ADR[p])).
  - cleared_this_cycle applies only with the bypass feature; otherwise that term is 0.
- Latency:
  - Without bypass, data written at edge N is readable after edge N.
  - PEND reflects issue/writeback one edge later.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - RD_DATA[p] returns WD of the highest-index port with WE=1 and WR_ADR==RD_ADR[p]≠0 in the same cycle.
  - Such a read does not contribute to STALL, even if PEND is still 1.
- Undefined:
  - Same-cycle reads return the old MEM value.
  - STALL is asserted purely from PEND.

Decomposition:
- Package regfile_pkg holds:
  - the AW computation function;
  - default WIDTH/REG_NUM/NRD/NWR constants;
  - the REG_ZERO = 0 constant.
- Sub-module regfile_scoreboard (REG_NUM, NWR, AW) owns the PEND register and the set/clear priority logic.
- Data array and read muxing/bypass stay in the top module.

Test Plan:
1. Reset and zero register:
   - Write 0xDEADBEEF to r0 via port 0, then read r0 -> RD_DATA=0.
   - Assert RST mid-write -> all reads 0, PEND=0.
2. Multi-write collision:
   - WE=2'b11, both WR_ADR=5, WD0=0x11, WD1=0x22 -> next cycle r5 reads 0x22.
   - Both ports reading r5 see 0x22.
3. Scoreboard stall:
   - Issue r7, then RD_EN[1]=1, RD_ADR[1]=7 -> STALL=1.
   - Writeback WE[0] to r7 with 0x1234 -> next cycle PEND[7]=0, STALL=0, RD_DATA[1]=0x1234.
4. Set/clear race:
   - PEND[9]=1; same cycle write r9 and ISSUE_VLD with ISSUE_ADR=9 -> PEND[9] stays 1, r9 holds new data.
5. Bypass (REGFILE_BYPASS_EN):
   - r3 pending; write r3=0xCAFE while reading r3 -> RD_DATA=0xCAFE same cycle, STALL=0.
   - Without the macro: RD_DATA=old value, STALL=1.
6. RD_EN gating:
   - r4 pending, RD_ADR[0]=4 with RD_EN[0]=0 -> STALL=0.
   - Issue to r0 -> PEND[0] remains 0.
